// File: rtl/pipeio_resp_pkg.sv
// pipeio_resp_pkg: shared I/O register map constants used by the I/O block and the MEM-stage address decode
package pipeio_resp_pkg;
  typedef enum logic [2:0] {
    REG_OUT0,
    REG_OUT1,
    REG_IN0,
    REG_IN1,
    REG_STATUS,
    REG_IRQ_EN,
    REG_TIMER,
    REG_CMP
  } io_reg_e;
  localparam int ST_IN0 = 0;
  localparam int ST_IN1 = 1;
  localparam int ST_TMR = 2;
  localparam int IRQ_W = 3;
  localparam int IO_SPAN_LSB = 5;
  function automatic logic [4:0] reg_offset(io_reg_e r);
    return {r, 2'b00};
  endfunction
endpackage

// File: rtl/pipeio_resp_io_sync_edge.sv
// io_sync_edge: multi-flop synchronizer for an asynchronous word plus change detect on the synchronized value
module io_sync_edge #(
  parameter int STAGES = 2,
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic         chg_o
);
  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] hist_q;
  // shift chain plus one-cycle history; both reset to 0 so release produces no change
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  assign sync_o = sync_q[STAGES-1];
  assign chg_o = sync_o != hist_q;
endmodule

// File: rtl/pipeio_resp.sv
// pipeio_resp: memory-mapped I/O block with output/input ports, sticky status, timer/compare and irq
module pipeio_resp
  import pipeio_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              io_we,
  input  logic              io_re,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [31:0]       in_port0,
  input  logic [31:0]       in_port1,
  output logic [31:0]       out_port0,
  output logic [31:0]       out_port1,
  output logic              irq
);
  logic [31:0] out0_q, out0_d, out1_q, out1_d, timer_q, timer_d, cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d, rd_val, in0_s, in1_s;
  logic [IRQ_W-1:0] status_q, status_d, irq_en_q, irq_en_d, st_set, st_clr;
  logic run_q, chg0, chg1, hit, wr, unused_ok;
  io_reg_e idx;

  io_sync_edge #(.STAGES(SYNC_STAGES), .W(32)) u_sync0 (
    .clock(clock), .resetn(resetn), .async_i(in_port0), .sync_o(in0_s), .chg_o(chg0)
  );
  io_sync_edge #(.STAGES(SYNC_STAGES), .W(32)) u_sync1 (
    .clock(clock), .resetn(resetn), .async_i(in_port1), .sync_o(in1_s), .chg_o(chg1)
  );

  assign hit = io_addr[ADDR_W-1:IO_SPAN_LSB] == '0;
  assign idx = io_reg_e'(io_addr[4:2]);
  assign wr = io_we && hit;
  assign unused_ok = ^io_addr[1:0];

  // read mux over pre-write register contents; unmapped space reads 0
  always_comb begin
    rd_val = '0;
    if (hit)
      case (idx)
        REG_OUT0:   rd_val = out0_q;
        REG_OUT1:   rd_val = out1_q;
        REG_IN0:    rd_val = in0_s;
        REG_IN1:    rd_val = in1_s;
        REG_STATUS: rd_val = 32'(status_q);
        REG_IRQ_EN: rd_val = 32'(irq_en_q);
        REG_TIMER:  rd_val = timer_q;
        REG_CMP:    rd_val = cmp_q;
      endcase
  end

  // next state: writes land on their strobe edge, TIMER free-runs, STATUS set beats clear
  always_comb begin
    out0_d = wr && idx == REG_OUT0 ? io_wdata : out0_q;
    out1_d = wr && idx == REG_OUT1 ? io_wdata : out1_q;
    irq_en_d = wr && idx == REG_IRQ_EN ? io_wdata[IRQ_W-1:0] : irq_en_q;
    timer_d = wr && idx == REG_TIMER ? io_wdata : timer_q + 32'd1;
    cmp_d = wr && idx == REG_CMP ? io_wdata : cmp_q;
    st_set = '0;
    st_set[ST_IN0] = chg0;
    st_set[ST_IN1] = chg1;
    st_set[ST_TMR] = run_q && timer_q == cmp_q;
    st_clr = wr && idx == REG_STATUS ? io_wdata[IRQ_W-1:0] : '0;
    status_d = (status_q & ~st_clr) | st_set;
    rdata_d = io_re ? rd_val : rdata_q;
  end

  // state registers; run_q masks the match of the reset TIMER against the reset CMP
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      out0_q   <= '0;
      out1_q   <= '0;
      irq_en_q <= '0;
      timer_q  <= '0;
      cmp_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      irq_en_q <= irq_en_d;
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      run_q    <= 1'b1;
    end

  assign io_rdata = rdata_q;
  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign irq = |(status_q & irq_en_q);
endmodule
